// File: rtl/carry_chain_seq8_if.sv
// Operand/result stream bundle for carry_chain_seq8.
// in_sub exists only when ADDSUB_EN is defined.
interface carry_chain_seq8_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       in_last;
`ifdef ADDSUB_EN
    logic       in_sub;
`endif
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic       out_ovf;
    logic       out_len_err;

    modport master (
`ifdef ADDSUB_EN
        output in_sub,
`endif
        output in_valid, in_a, in_b, in_cin, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, out_len_err
    );

    modport slave (
`ifdef ADDSUB_EN
        input  in_sub,
`endif
        input  in_valid, in_a, in_b, in_cin, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, out_len_err
    );
endinterface

// File: rtl/carry_chain_seq8.sv
// Sequential multi-byte adder: one 8-bit slice, carry registered between LSB-first beats.
// Optional ADDSUB_EN macro adds a per-word subtract mode (in_sub latched on the first beat).
//
// state | meaning
// IDLE  | next accepted beat is the first (least-significant) beat of a word
// BUSY  | mid-word; carry register feeds the next beat
module carry_chain_seq8 #(
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic              clk,
    input  logic              rst,
    carry_chain_seq8_if.slave bus
);

    localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_nxt;
    logic       c_q;
    logic [7:0] cnt_q;

    logic       accept;
    logic       first;
    logic       sub_eff;
    logic       cin_eff;
    logic [7:0] b_eff;
    logic [7:0] beat_num;
    logic [8:0] sum9;
    logic       c7;
    logic       hit_max;
    logic       last_eff;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign first        = (state == IDLE);

`ifdef ADDSUB_EN
    logic sub_q;

    assign sub_eff = first ? bus.in_sub : sub_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (accept && first) begin
            sub_q <= bus.in_sub;
        end
    end
`else
    assign sub_eff = 1'b0;
`endif

    always_comb begin
        cin_eff  = c_q;
        b_eff    = bus.in_b;
        if (first) begin
            cin_eff = sub_eff ? 1'b1 : bus.in_cin;
        end
        if (sub_eff) begin
            b_eff = ~bus.in_b;
        end
        sum9     = {1'b0, bus.in_a} + {1'b0, b_eff} + {8'd0, cin_eff};
        // carry into bit 7 recovered from the bit-7 sum
        c7       = bus.in_a[7] ^ b_eff[7] ^ sum9[7];
        beat_num = cnt_q + 8'd1;
        hit_max  = (beat_num == MAX_B);
        last_eff = bus.in_last || hit_max;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = last_eff ? IDLE : BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q   <= 1'b0;
            cnt_q <= 8'd0;
        end else if (accept) begin
            c_q   <= sum9[8];
            cnt_q <= last_eff ? 8'd0 : beat_num;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.out_sum     <= 8'd0;
            bus.out_last    <= 1'b0;
            bus.out_cout    <= 1'b0;
            bus.out_ovf     <= 1'b0;
            bus.out_len_err <= 1'b0;
        end else if (accept) begin
            bus.out_valid   <= 1'b1;
            bus.out_sum     <= sum9[7:0];
            bus.out_last    <= last_eff;
            bus.out_cout    <= sum9[8];
            bus.out_ovf     <= last_eff && (c7 ^ sum9[8]);
            bus.out_len_err <= hit_max && !bus.in_last;
        end else if (bus.out_ready) begin
            bus.out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_carry_chain_seq8.sv
// Bench for carry_chain_seq8: word-level arithmetic model checked every cycle,
// plus directed words with literal expected beats.
module tb_carry_chain_seq8;

    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    carry_chain_seq8_if bus();

    carry_chain_seq8 #(.MAX_BEATS(MAXB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // word-level model: whole operands accumulated as integers, result bytes sliced out
    bit          m_valid = 0, m_last = 0, m_cout = 0, m_ovf = 0, m_err = 0, m_inword = 0;
    logic [7:0]  m_sum = '0;
    logic [63:0] wa, wb, tot;
    int          wn;
    bit          wcin, wsub;

    bit          s_rst, s_acc, s_last, s_cin, s_sub, s_oready;
    logic [7:0]  s_a, s_b;
    logic [11:0] got_q[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_valid || bus.out_ready)});
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
            if (m_valid)
                check("out_beat",
                      {20'd0, bus.out_sum, bus.out_last, bus.out_cout, bus.out_ovf, bus.out_len_err},
                      {20'd0, m_sum, m_last, m_cout, m_ovf, m_err});
            if (bus.out_valid && bus.out_ready)
                got_q.push_back({bus.out_sum, bus.out_last, bus.out_cout, bus.out_ovf, bus.out_len_err});
        end
        s_rst    = rst;
        s_acc    = bus.in_valid && (!m_valid || bus.out_ready);
        s_a      = bus.in_a;
        s_b      = bus.in_b;
        s_cin    = bus.in_cin;
        s_last   = bus.in_last;
        s_oready = bus.out_ready;
`ifdef ADDSUB_EN
        s_sub    = bus.in_sub;
`else
        s_sub    = 1'b0;
`endif
    end

    always @(posedge clk) begin
        if (s_rst) begin
            m_valid = 0; m_sum = '0; m_last = 0; m_cout = 0; m_ovf = 0; m_err = 0;
            m_inword = 0;
        end else if (s_acc) begin
            if (!m_inword) begin
                wa = '0; wb = '0; wn = 0; wcin = s_cin; wsub = s_sub;
            end
            wa[8*wn +: 8] = s_a;
            wb[8*wn +: 8] = wsub ? ~s_b : s_b;
            wn++;
            tot      = wa + wb + 64'(wsub ? 1'b1 : wcin);
            m_sum    = tot[8*(wn-1) +: 8];
            m_cout   = tot[8*wn];
            m_last   = s_last || (wn == MAXB);
            m_err    = (wn == MAXB) && !s_last;
            m_ovf    = m_last && (wa[8*wn-1] == wb[8*wn-1]) && (tot[8*wn-1] != wa[8*wn-1]);
            m_inword = !m_last;
            m_valid  = 1;
        end else if (s_oready) begin
            m_valid = 0;
        end
    end

    // all stimulus tasks start and end at posedge+1
    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit cin,
                        input bit last, input bit sub);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_last  = last;
`ifdef ADDSUB_EN
        bus.in_sub   = sub;
`else
        if (sub) $display("note: subtract beat sent without ADDSUB_EN");
`endif
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        check("send_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string nm, input int idx, input logic [7:0] sum,
                            input bit last, input bit cout, input bit ovf, input bit err);
        if (idx < got_q.size())
            check(nm, {20'd0, got_q[idx]}, {20'd0, sum, last, cout, ovf, err});
        else
            check({nm, "_missing"}, got_q.size(), idx + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_last   = 1'b0;
`ifdef ADDSUB_EN
        bus.in_sub    = 1'b0;
`endif
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_sum",   {24'd0, bus.out_sum}, 32'd0);
        check("rst_out_flags", {28'd0, bus.out_last, bus.out_cout, bus.out_ovf, bus.out_len_err}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 0x12FF + 0x0001
        got_q.delete();
        send(8'hFF, 8'h01, 0, 0, 0);
        send(8'h12, 8'h00, 0, 1, 0);
        drain();
        chk_beat("add16_b0", 0, 8'h00, 0, 1, 0, 0);
        chk_beat("add16_b1", 1, 8'h13, 1, 0, 0, 0);

        // 0x7FFFFFFF + 1, back-to-back
        got_q.delete();
        send(8'hFF, 8'h01, 0, 0, 0);
        send(8'hFF, 8'h00, 0, 0, 0);
        send(8'hFF, 8'h00, 0, 0, 0);
        send(8'h7F, 8'h00, 0, 1, 0);
        drain();
        chk_beat("add32_b0", 0, 8'h00, 0, 1, 0, 0);
        chk_beat("add32_b1", 1, 8'h00, 0, 1, 0, 0);
        chk_beat("add32_b2", 2, 8'h00, 0, 1, 0, 0);
        chk_beat("add32_b3", 3, 8'h80, 1, 0, 1, 0);

        // stall after the first beat of the 0x12FF + 0x0001 word
        got_q.delete();
        send(8'hFF, 8'h01, 0, 0, 0);
        bus.out_ready = 1'b0;
        bus.in_a = 8'h12; bus.in_b = 8'h00; bus.in_cin = 1'b0; bus.in_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_sum", {24'd0, bus.out_sum}, 32'h00);
            check("stall_cout", {31'd0, bus.out_cout}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(8'h12, 8'h00, 0, 1, 0);
        drain();
        chk_beat("stall_b0", 0, 8'h00, 0, 1, 0, 0);
        chk_beat("stall_b1", 1, 8'h13, 1, 0, 0, 0);

        // length limit: no in_last, fifth beat restarts from in_cin
        got_q.delete();
        repeat (5) send(8'hFF, 8'h00, 1, 0, 0);
        send(8'h01, 8'h01, 0, 1, 0);
        drain();
        chk_beat("len_b0", 0, 8'h00, 0, 1, 0, 0);
        chk_beat("len_b3", 3, 8'h00, 1, 1, 0, 1);
        chk_beat("len_b4", 4, 8'h00, 0, 1, 0, 0);
        chk_beat("len_b5", 5, 8'h03, 1, 0, 0, 0);

        // reset mid-word discards the pending carry
        send(8'hFF, 8'h01, 0, 0, 0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        @(negedge clk);
        check("rst2_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst2_out_sum", {24'd0, bus.out_sum}, 32'd0);
        @(posedge clk);
        #1;
        send(8'h01, 8'h01, 0, 1, 0);
        drain();
        chk_beat("rst2_b0", 0, 8'h02, 1, 0, 0, 0);

`ifdef ADDSUB_EN
        // 0x0100 - 0x0001; in_cin must be ignored in subtract mode
        got_q.delete();
        send(8'h00, 8'h01, 0, 0, 1);
        send(8'h01, 8'h00, 1, 1, 0);
        drain();
        chk_beat("sub_b0", 0, 8'hFF, 0, 0, 0, 0);
        chk_beat("sub_b1", 1, 8'h00, 1, 1, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/carry_chain_seq8.md
# carry_chain_seq8

Sequential multi-byte adder stage that wraps the 8-bit carry-bypass adder datapath. Consumes a stream of operand byte pairs (least-significant byte first), adds each pair with the carry registered from the previous beat, and emits one registered sum byte per beat. Sits directly upstream of result consumers and downstream of the operand source. Builds 16/24/32-bit and wider additions from one 8-bit adder slice.

## Interface
- MAX_BEATS, 4: maximum beats per word; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  stage can accept a beat.
- in_a  in  8  operand A byte.
- in_b  in  8  operand B byte.
- in_cin  in  1  carry-in; sampled only on the first beat of a word.
- in_last  in  1  marks the final (most-significant) beat.
- in_sub  in  1  subtract A−B; sampled on first beat (present only with ADDSUB_EN).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result beat.
- out_sum  out  8  sum byte.
- out_last  out  1  final beat of the word.
- out_cout  out  1  carry out of bit 7 of this beat.
- out_ovf  out  1  signed overflow; meaningful only when out_last=1, otherwise 0.
- out_len_err  out  1  word was force-terminated at MAX_BEATS.

## Operation
- Beat transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- FSM states:
  - IDLE: next accepted beat is a first beat.
  - BUSY: mid-word.
  - Transitions:
    - IDLE→BUSY on an accepted beat with in_last=0 and beat count < MAX_BEATS.
    - BUSY→IDLE on an accepted beat with in_last=1, or on the MAX_BEATS-th beat.
    - Otherwise hold state.
- Carry register c:
  - First beat uses in_cin (in_sub=1 with ADDSUB_EN: uses 1).
  - Later beats use c.
  - After every accepted beat, c ← cout of that beat.
- Per beat: {cout, sum} = a + b' + cin_eff (9-bit), where b' = ~in_b if the latched sub mode is set, else in_b.
- ovf = carry into bit 7 XOR carry out of bit 7; reported on the last beat only.
- Beat counter (8 bits): cleared on entering IDLE, incremented per accepted beat.
  - If the MAX_BEATS-th beat arrives with in_last=0, it is emitted with out_last=1 and out_len_err=1, and the FSM returns to IDLE.
  - The following input beat starts a new word.
- MAX_BEATS=1: every beat is a complete word; out_last is always 1.

## Timing
- Reset values:
  - out_valid=0, out_sum=0, out_last=0, out_cout=0, out_ovf=0, out_len_err=0.
  - c=0, counter=0, FSM=IDLE, sub mode=0.
- in_ready = !out_valid || out_ready (combinational; single output register with pass-through).
- Latency: 1 cycle from accepted beat to out_valid.
- Throughput: 1 beat/cycle under continuous out_ready=1.
- Output stall (out_valid=1, out_ready=0):
  - Output registers hold stable.
  - in_ready=0; c and counter frozen.
- Simultaneous output transfer and input beat in one cycle: the new result loads, out_valid stays 1.
- A bubble (in_valid=0) mid-word keeps state, c and counter; the carry chain continues on the next beat.
- rst asserted mid-word: state, c, counter and output register are discarded; the next beat after rst is a first beat.

## Configuration
- ADDSUB_EN defined:
  - in_sub port exists and is latched on the first beat for the whole word.
  - Subtract inverts B and forces cin_eff=1 on the first beat; in_cin is ignored in subtract mode.
  - out_cout=1 on the last beat means no borrow.
- ADDSUB_EN undefined: no in_sub port; add only.

## Test plan
- 16-bit add, 2 beats (A=0x12FF, B=0x0001, cin=0; beats LSB first) -> sums 0x00 (cout=1), then 0x13 (last, cout=0, ovf=0).
- 32-bit add 0x7FFFFFFF+0x00000001 in 4 beats -> bytes 00,00,00,80; last beat ovf=1, cout=0.
- out_ready held low 3 cycles after beat 1 of a 2-beat word -> out_sum stable, in_ready=0, carry preserved; final result identical to the unstalled run.
- MAX_BEATS=4, 5 beats of 0xFF+0x00 with cin=1 and no in_last -> 4th beat shows out_last=1 and out_len_err=1; 5th beat restarts with carry from in_cin.
- rst pulsed after beat 1 of a word with carry=1 -> outputs zero; next beat 0x01+0x01, cin=0 gives 0x02 (stale carry not applied).
- ADDSUB_EN: 0x0100−0x0001 in 2 beats, in_sub=1 -> 0xFF (cout=0), then 0x00 (cout=1, no borrow, ovf=0).
